// File: rtl/id_decode_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_queue_pkg
// Purpose  : uop field layout, decode enums and the uop pack helper shared
//            by the decode queue and its per-slot packer.
// Revision : 1.0 - initial parametrised decode queue
// ============================================================================
package id_decode_queue_pkg;

   localparam int IMM_W         = 32;
   localparam int REG_W         = 5;
   localparam int SRC_SEL_W     = 2;
   localparam int ALU_OP_W      = 4;
   localparam int RS_ENT_W      = 2;
   localparam int DMEM_SIZE_W   = 2;
   localparam int DMEM_TYPE_W   = 2;
   localparam int MD_OP_W       = 2;
   localparam int MD_OUT_SEL_W  = 2;
   localparam int IMM_TYPE_W    = 3;

   localparam int IMM_OFF         = 0;
   localparam int RS1_OFF         = IMM_OFF + IMM_W;
   localparam int RS2_OFF         = RS1_OFF + REG_W;
   localparam int RD_OFF          = RS2_OFF + REG_W;
   localparam int SRC_A_SEL_OFF   = RD_OFF + REG_W;
   localparam int SRC_B_SEL_OFF   = SRC_A_SEL_OFF + SRC_SEL_W;
   localparam int WR_REG_OFF      = SRC_B_SEL_OFF + SRC_SEL_W;
   localparam int USES_RS1_OFF    = WR_REG_OFF + 1;
   localparam int USES_RS2_OFF    = USES_RS1_OFF + 1;
   localparam int ILLEGAL_OFF     = USES_RS2_OFF + 1;
   localparam int ALU_OP_OFF      = ILLEGAL_OFF + 1;
   localparam int RS_ENT_OFF      = ALU_OP_OFF + ALU_OP_W;
   localparam int DMEM_SIZE_OFF   = RS_ENT_OFF + RS_ENT_W;
   localparam int DMEM_TYPE_OFF   = DMEM_SIZE_OFF + DMEM_SIZE_W;
   localparam int MD_OP_OFF       = DMEM_TYPE_OFF + DMEM_TYPE_W;
   localparam int MD_A_SIGNED_OFF = MD_OP_OFF + MD_OP_W;
   localparam int MD_B_SIGNED_OFF = MD_A_SIGNED_OFF + 1;
   localparam int MD_OUT_SEL_OFF  = MD_B_SIGNED_OFF + 1;
   localparam int IMM_TYPE_OFF    = MD_OUT_SEL_OFF + MD_OUT_SEL_W;
   localparam int UOP_W           = IMM_TYPE_OFF + IMM_TYPE_W;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

   // ALU ops are {alt, funct3}; branch uops reuse the field as {1, funct3}
   // and are told apart by their RS_BR entry.
   localparam logic [3:0] ALU_ADD = 4'h0;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   typedef enum logic [1:0] {SRC_A_RS1 = 2'd0, SRC_A_PC = 2'd1, SRC_A_ZERO = 2'd2} src_a_e;
   typedef enum logic [1:0] {SRC_B_RS2 = 2'd0, SRC_B_IMM = 2'd1, SRC_B_FOUR = 2'd2} src_b_e;
   typedef enum logic [1:0] {RS_ALU = 2'd0, RS_MEM = 2'd1, RS_MD = 2'd2, RS_BR = 2'd3} rs_ent_e;
   typedef enum logic [1:0] {DMEM_NONE = 2'd0, DMEM_LOAD = 2'd1, DMEM_LOADU = 2'd2, DMEM_STORE = 2'd3} dmem_type_e;
   typedef enum logic [1:0] {MD_MUL = 2'd0, MD_DIV = 2'd1, MD_REM = 2'd2} md_op_e;

   typedef struct packed {
      logic [IMM_W-1:0]        imm;
      logic [REG_W-1:0]        rs1;
      logic [REG_W-1:0]        rs2;
      logic [REG_W-1:0]        rd;
      src_a_e                  src_a_sel;
      src_b_e                  src_b_sel;
      logic                    wr_reg;
      logic                    uses_rs1;
      logic                    uses_rs2;
      logic                    illegal;
      logic [ALU_OP_W-1:0]     alu_op;
      rs_ent_e                 rs_ent;
      logic [DMEM_SIZE_W-1:0]  dmem_size;
      dmem_type_e              dmem_type;
      md_op_e                  md_op;
      logic                    md_a_signed;
      logic                    md_b_signed;
      logic [MD_OUT_SEL_W-1:0] md_out_sel;
      imm_type_e               imm_type;
   } uop_t;

   function automatic logic [UOP_W-1:0] pack_uop(input uop_t u);
      logic [UOP_W-1:0] v;
      v = '0;
      v[IMM_OFF        +: IMM_W]        = u.imm;
      v[RS1_OFF        +: REG_W]        = u.rs1;
      v[RS2_OFF        +: REG_W]        = u.rs2;
      v[RD_OFF         +: REG_W]        = u.rd;
      v[SRC_A_SEL_OFF  +: SRC_SEL_W]    = u.src_a_sel;
      v[SRC_B_SEL_OFF  +: SRC_SEL_W]    = u.src_b_sel;
      v[WR_REG_OFF]                     = u.wr_reg;
      v[USES_RS1_OFF]                   = u.uses_rs1;
      v[USES_RS2_OFF]                   = u.uses_rs2;
      v[ILLEGAL_OFF]                    = u.illegal;
      v[ALU_OP_OFF     +: ALU_OP_W]     = u.alu_op;
      v[RS_ENT_OFF     +: RS_ENT_W]     = u.rs_ent;
      v[DMEM_SIZE_OFF  +: DMEM_SIZE_W]  = u.dmem_size;
      v[DMEM_TYPE_OFF  +: DMEM_TYPE_W]  = u.dmem_type;
      v[MD_OP_OFF      +: MD_OP_W]      = u.md_op;
      v[MD_A_SIGNED_OFF]                = u.md_a_signed;
      v[MD_B_SIGNED_OFF]                = u.md_b_signed;
      v[MD_OUT_SEL_OFF +: MD_OUT_SEL_W] = u.md_out_sel;
      v[IMM_TYPE_OFF   +: IMM_TYPE_W]   = u.imm_type;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_decode_queue_uop_packer.sv
`default_nettype none
// ============================================================================
// Module   : id_uop_packer
// Purpose  : One decode slot: RV32IM decoder, immediate decoder, uop packing.
// Revision : 1.0 - initial parametrised decode queue
// ============================================================================
module id_uop_packer
   import id_decode_queue_pkg::*;
(
   input  logic [31:0]      i_inst,
   output logic [UOP_W-1:0] o_uop,
   output logic             o_illegal
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   uop_t        w_dec;
   uop_t        w_uop;
   logic [31:0] w_imm;

   assign w_opcode = i_inst[6:0];
   assign w_f3     = i_inst[14:12];
   assign w_f7     = i_inst[31:25];

   always_comb begin
      w_dec           = '0;
      w_dec.rs1       = i_inst[19:15];
      w_dec.rs2       = i_inst[24:20];
      w_dec.rd        = i_inst[11:7];
      w_dec.src_a_sel = SRC_A_RS1;
      w_dec.src_b_sel = SRC_B_RS2;
      w_dec.rs_ent    = RS_ALU;
      w_dec.dmem_type = DMEM_NONE;
      w_dec.md_op     = MD_MUL;
      w_dec.imm_type  = IMM_NONE;
      w_dec.alu_op    = ALU_ADD;
      case (w_opcode)
         OPC_LUI, OPC_AUIPC: begin
            w_dec.wr_reg    = 1'b1;
            w_dec.imm_type  = IMM_U;
            w_dec.src_a_sel = (w_opcode == OPC_LUI) ? SRC_A_ZERO : SRC_A_PC;
            w_dec.src_b_sel = SRC_B_IMM;
         end
         OPC_JAL, OPC_JALR: begin
            w_dec.wr_reg    = 1'b1;
            w_dec.uses_rs1  = (w_opcode == OPC_JALR);
            w_dec.imm_type  = (w_opcode == OPC_JALR) ? IMM_I : IMM_J;
            w_dec.src_a_sel = SRC_A_PC;
            w_dec.src_b_sel = SRC_B_FOUR;
            w_dec.rs_ent    = RS_BR;
            w_dec.illegal   = (w_opcode == OPC_JALR) && (w_f3 != 3'd0);
         end
         OPC_BRANCH: begin
            w_dec.uses_rs1  = 1'b1;
            w_dec.uses_rs2  = 1'b1;
            w_dec.imm_type  = IMM_B;
            w_dec.src_a_sel = SRC_A_PC;
            w_dec.src_b_sel = SRC_B_IMM;
            w_dec.rs_ent    = RS_BR;
            w_dec.alu_op    = {1'b1, w_f3};
            w_dec.illegal   = (w_f3[2:1] == 2'b01);
         end
         OPC_LOAD: begin
            w_dec.wr_reg    = 1'b1;
            w_dec.uses_rs1  = 1'b1;
            w_dec.imm_type  = IMM_I;
            w_dec.src_b_sel = SRC_B_IMM;
            w_dec.rs_ent    = RS_MEM;
            w_dec.dmem_size = w_f3[1:0];
            w_dec.dmem_type = w_f3[2] ? DMEM_LOADU : DMEM_LOAD;
            w_dec.illegal   = (w_f3 == 3'd3) || (w_f3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            w_dec.uses_rs1  = 1'b1;
            w_dec.uses_rs2  = 1'b1;
            w_dec.imm_type  = IMM_S;
            w_dec.src_b_sel = SRC_B_IMM;
            w_dec.rs_ent    = RS_MEM;
            w_dec.dmem_size = w_f3[1:0];
            w_dec.dmem_type = DMEM_STORE;
            w_dec.illegal   = (w_f3 > 3'd2);
         end
         OPC_OP_IMM: begin
            w_dec.wr_reg    = 1'b1;
            w_dec.uses_rs1  = 1'b1;
            w_dec.imm_type  = IMM_I;
            w_dec.src_b_sel = SRC_B_IMM;
            w_dec.alu_op    = {(w_f3 == 3'd5) && i_inst[30], w_f3};
            w_dec.illegal   = ((w_f3 == 3'd1) && (w_f7 != 7'h00)) ||
                              ((w_f3 == 3'd5) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
         end
         OPC_OP: begin
            w_dec.wr_reg    = 1'b1;
            w_dec.uses_rs1  = 1'b1;
            w_dec.uses_rs2  = 1'b1;
            if (w_f7 == 7'h01) begin
               w_dec.rs_ent      = RS_MD;
               w_dec.md_op       = w_f3[2] ? (w_f3[1] ? MD_REM : MD_DIV) : MD_MUL;
               w_dec.md_a_signed = w_f3[2] ? ~w_f3[0] : (w_f3 != 3'd3);
               w_dec.md_b_signed = w_f3[2] ? ~w_f3[0] : (w_f3[2:1] == 2'b00);
               w_dec.md_out_sel  = {1'b0, ~w_f3[2] && (w_f3[1:0] != 2'b00)};
            end else begin
               w_dec.alu_op  = {w_f7[5], w_f3};
               w_dec.illegal = (w_f7 != 7'h00) &&
                               !((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)));
            end
         end
         OPC_MISC_MEM: ;
         // SYSTEM/CSR and anything unknown trap through the illegal path
         default: w_dec.illegal = 1'b1;
      endcase
      if (w_dec.illegal) begin
         w_dec         = '0;
         w_dec.illegal = 1'b1;
      end
   end

   always_comb begin
      case (w_dec.imm_type)
         IMM_I:   w_imm = {{20{i_inst[31]}}, i_inst[31:20]};
         IMM_S:   w_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         IMM_B:   w_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
         IMM_U:   w_imm = {i_inst[31:12], 12'h000};
         IMM_J:   w_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
         default: w_imm = '0;
      endcase
   end

   always_comb begin
      w_uop     = w_dec;
      w_uop.imm = w_imm;
   end

   assign o_uop     = pack_uop(w_uop);
   assign o_illegal = w_dec.illegal;

endmodule
`default_nettype wire

// File: rtl/id_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_queue
// Purpose  : Decodes DEC_WIDTH RV32 slots per bundle into a DEPTH-entry FIFO
//            with valid/ready on both sides. ID_BYPASS_EN adds empty bypass.
// Revision : 1.0 - initial parametrised decode queue
// ============================================================================
module id_decode_queue
   import id_decode_queue_pkg::*;
#(
   parameter int DEC_WIDTH = 2,
   parameter int DEPTH     = 4,
   parameter int PTR_W     = $clog2(DEPTH)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       kill_i,
   input  logic                       if_valid_i,
   output logic                       if_ready_o,
   input  logic [DEC_WIDTH*32-1:0]    if_inst_i,
   input  logic [DEC_WIDTH-1:0]       if_mask_i,
   input  logic [31:0]                if_pc_i,
   output logic                       dp_valid_o,
   input  logic                       dp_ready_i,
   output logic [DEC_WIDTH*UOP_W-1:0] dp_uop_o,
   output logic [DEC_WIDTH-1:0]       dp_mask_o,
   output logic [31:0]                dp_pc_o,
   output logic [PTR_W:0]             dp_count_o
);

   localparam int BUN_W = DEC_WIDTH * UOP_W;

   logic [BUN_W-1:0]     w_uop;
   logic [DEC_WIDTH-1:0] w_illegal;
   logic [DEC_WIDTH-1:0] w_mask;
   logic                 w_cut;

   generate
      for (genvar g = 0; g < DEC_WIDTH; g++) begin : g_slot
         id_uop_packer u_packer (
            .i_inst    (if_inst_i[g*32 +: 32]),
            .o_uop     (w_uop[g*UOP_W +: UOP_W]),
            .o_illegal (w_illegal[g])
         );
      end
   endgenerate

   // The first valid illegal slot survives so dispatch can trap on it;
   // everything younger in the bundle is dropped.
   always_comb begin
      w_mask = if_mask_i;
      w_cut  = 1'b0;
      for (int i = 0; i < DEC_WIDTH; i++) begin
         if (w_cut) begin
            w_mask[i] = 1'b0;
         end else if (if_mask_i[i] && w_illegal[i]) begin
            w_cut = 1'b1;
         end
      end
   end

   logic [BUN_W-1:0]     r_mem_uop  [DEPTH];
   logic [DEC_WIDTH-1:0] r_mem_mask [DEPTH];
   logic [31:0]          r_mem_pc   [DEPTH];

   logic [PTR_W-1:0]     r_rd_ptr, r_wr_ptr, w_rd_nxt, w_wr_nxt;
   logic [PTR_W:0]       r_count, w_cnt_nxt;
   logic [BUN_W-1:0]     r_head_uop;
   logic [DEC_WIDTH-1:0] r_head_mask;
   logic [31:0]          r_head_pc;
   logic                 w_full, w_has_head, w_bypass, w_push, w_pop;

   assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
   assign w_has_head = (r_count != '0);
   assign if_ready_o = ~w_full & ~reset_i;

`ifdef ID_BYPASS_EN
   assign w_bypass = ~w_has_head & if_valid_i & if_ready_o & (|if_mask_i) & dp_ready_i & ~kill_i;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = if_valid_i & if_ready_o & ~kill_i & (|if_mask_i) & ~w_bypass;
   assign w_pop  = w_has_head & dp_ready_i & ~kill_i;

   always_comb begin
      w_rd_nxt  = r_rd_ptr + PTR_W'(w_pop);
      w_wr_nxt  = r_wr_ptr + PTR_W'(w_push);
      w_cnt_nxt = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      if (kill_i) begin
         w_rd_nxt  = '0;
         w_wr_nxt  = '0;
         w_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_uop[r_wr_ptr]  <= w_uop;
         r_mem_mask[r_wr_ptr] <= w_mask;
         r_mem_pc[r_wr_ptr]   <= if_pc_i;
      end
   end

   // Head registers preload the next head so dp_* never see the RAM read path;
   // a bundle written this edge becomes head straight from the input.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_head_uop  <= '0;
         r_head_mask <= '0;
         r_head_pc   <= '0;
      end else begin
         r_rd_ptr <= w_rd_nxt;
         r_wr_ptr <= w_wr_nxt;
         r_count  <= w_cnt_nxt;
         if (w_cnt_nxt != '0) begin
            if (w_push && (w_rd_nxt == r_wr_ptr)) begin
               r_head_uop  <= w_uop;
               r_head_mask <= w_mask;
               r_head_pc   <= if_pc_i;
            end else begin
               r_head_uop  <= r_mem_uop[w_rd_nxt];
               r_head_mask <= r_mem_mask[w_rd_nxt];
               r_head_pc   <= r_mem_pc[w_rd_nxt];
            end
         end
      end
   end

   assign dp_count_o = r_count;

`ifdef ID_BYPASS_EN
   always_comb begin
      if (w_bypass) begin
         dp_valid_o = 1'b1;
         dp_uop_o   = w_uop;
         dp_mask_o  = w_mask;
         dp_pc_o    = if_pc_i;
      end else begin
         dp_valid_o = w_has_head;
         dp_uop_o   = r_head_uop;
         dp_mask_o  = w_has_head ? r_head_mask : '0;
         dp_pc_o    = r_head_pc;
      end
   end
`else
   assign dp_valid_o = w_has_head;
   assign dp_uop_o   = r_head_uop;
   assign dp_mask_o  = w_has_head ? r_head_mask : '0;
   assign dp_pc_o    = r_head_pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_decode_queue
// Purpose  : Directed plus random bench for id_decode_queue against a queue
//            model built from generated instruction fields.
// Revision : 1.0 - initial bench
// ============================================================================
module tb_id_decode_queue;
   import id_decode_queue_pkg::*;

   localparam int DW    = 2;
   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [2:0] K_ADDI = 3'd0, K_ADD = 3'd1, K_LUI = 3'd2, K_SW = 3'd3, K_BAD = 3'd4;
`ifdef ID_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  kind;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic [31:0] inst;
   } slot_t;

   typedef struct packed {
      slot_t [DW-1:0]  slot;
      logic [DW-1:0]   mask_in;
      logic [DW-1:0]   mask_exp;
      logic [31:0]     pc;
   } bundle_t;

   logic                clk_i = 1'b0;
   logic                reset_i, kill_i, if_valid_i, dp_ready_i;
   logic                if_ready_o, dp_valid_o;
   logic [DW*32-1:0]    if_inst_i;
   logic [DW-1:0]       if_mask_i, dp_mask_o;
   logic [31:0]         if_pc_i, dp_pc_o;
   logic [DW*UOP_W-1:0] dp_uop_o;
   logic [PTR_W:0]      dp_count_o;

   bundle_t model_q[$];
   int      n_cmp = 0;
   int      n_err = 0;

   always #5 clk_i = ~clk_i;

   id_decode_queue #(.DEC_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .kill_i(kill_i),
      .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_inst_i(if_inst_i),
      .if_mask_i(if_mask_i), .if_pc_i(if_pc_i),
      .dp_valid_o(dp_valid_o), .dp_ready_i(dp_ready_i), .dp_uop_o(dp_uop_o),
      .dp_mask_o(dp_mask_o), .dp_pc_o(dp_pc_o), .dp_count_o(dp_count_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic slot_t mk_slot(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] r);
      slot_t s;
      s = '0; s.kind = k; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
      case (k)
         K_ADDI: begin s.imm = {{20{r[11]}}, r[11:0]}; s.inst = {r[11:0], rs1, 3'b000, rd, 7'b0010011}; end
         K_ADD:  begin s.imm = '0; s.inst = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}; end
         K_LUI:  begin s.imm = {r[19:0], 12'h000}; s.inst = {r[19:0], rd, 7'b0110111}; end
         K_SW:   begin s.imm = {{20{r[11]}}, r[11:0]}; s.inst = {r[11:5], rs2, rs1, 3'b010, r[4:0], 7'b0100011}; end
         default: s.inst = {r[24:0], 7'b0000000};
      endcase
      return s;
   endfunction

   function automatic bundle_t mk_bundle(input slot_t [DW-1:0] sl, input logic [DW-1:0] m, input logic [31:0] pc);
      bundle_t b;
      bit cut;
      b = '0; b.slot = sl; b.mask_in = m; b.pc = pc; cut = 1'b0;
      for (int s = 0; s < DW; s++) begin
         b.mask_exp[s] = m[s] && !cut;
         if (m[s] && sl[s].kind == K_BAD) cut = 1'b1;
      end
      return b;
   endfunction

   function automatic slot_t rand_slot();
      int k;
      logic [2:0] kind;
      k = $urandom_range(0, 9);
      kind = (k >= 8) ? K_BAD : 3'(k % 4);
      return mk_slot(kind, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
   endfunction

   function automatic bundle_t rand_bundle(input bit nonzero);
      slot_t [DW-1:0] sl;
      logic [DW-1:0] m;
      for (int s = 0; s < DW; s++) sl[s] = rand_slot();
      m = (!nonzero && $urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, (1 << DW) - 1));
      return mk_bundle(sl, m, $urandom & 32'hFFFF_FFFC);
   endfunction

   task automatic check_outputs(input bit byp, input bundle_t inb);
      int          sz;
      bit          vexp;
      bundle_t     h;
      logic [UOP_W-1:0] u;
      logic [2:0]  k;
      bit          wr, u1, u2;
      sz   = model_q.size();
      vexp = byp || (sz != 0);
      chk("dp_valid", 64'(dp_valid_o), 64'(vexp));
      chk("dp_count", 64'(dp_count_o), 64'(sz));
      chk("if_ready", 64'(if_ready_o), 64'(sz < DEPTH));
      chk("count_bound", 64'(dp_count_o <= DEPTH), 64'd1);
      if (!vexp) begin
         chk("dp_mask_idle", 64'(dp_mask_o), 64'd0);
      end else begin
         h = byp ? inb : model_q[0];
         chk("dp_mask", 64'(dp_mask_o), 64'(h.mask_exp));
         chk("dp_pc", 64'(dp_pc_o), 64'(h.pc));
         for (int s = 0; s < DW; s++) begin
            if (h.mask_exp[s]) begin
               u  = dp_uop_o[s*UOP_W +: UOP_W];
               k  = h.slot[s].kind;
               wr = (k == K_ADDI) || (k == K_ADD) || (k == K_LUI);
               u1 = (k == K_ADDI) || (k == K_ADD) || (k == K_SW);
               u2 = (k == K_ADD) || (k == K_SW);
               chk($sformatf("s%0d_illegal", s), 64'(u[ILLEGAL_OFF]), 64'(k == K_BAD));
               if (k != K_BAD) begin
                  chk($sformatf("s%0d_wr_reg", s), 64'(u[WR_REG_OFF]), 64'(wr));
                  chk($sformatf("s%0d_uses_rs1", s), 64'(u[USES_RS1_OFF]), 64'(u1));
                  chk($sformatf("s%0d_uses_rs2", s), 64'(u[USES_RS2_OFF]), 64'(u2));
                  chk($sformatf("s%0d_imm", s), 64'(u[IMM_OFF +: IMM_W]), 64'(h.slot[s].imm));
                  if (wr) chk($sformatf("s%0d_rd", s), 64'(u[RD_OFF +: REG_W]), 64'(h.slot[s].rd));
                  if (u1) chk($sformatf("s%0d_rs1", s), 64'(u[RS1_OFF +: REG_W]), 64'(h.slot[s].rs1));
                  if (u2) chk($sformatf("s%0d_rs2", s), 64'(u[RS2_OFF +: REG_W]), 64'(h.slot[s].rs2));
               end
            end
         end
      end
   endtask

   task automatic step(input bit v, input bundle_t b, input bit rdy, input bit kl);
      bit byp, push, pop;
      @(negedge clk_i);
      if_valid_i = v; if_mask_i = b.mask_in; if_pc_i = b.pc;
      dp_ready_i = rdy; kill_i = kl;
      for (int s = 0; s < DW; s++) if_inst_i[s*32 +: 32] = b.slot[s].inst;
      #1;
      byp  = BYP && (model_q.size() == 0) && v && (b.mask_in != '0) && rdy && !kl;
      check_outputs(byp, b);
      push = v && (model_q.size() < DEPTH) && !kl && (b.mask_in != '0) && !byp;
      pop  = (model_q.size() != 0) && rdy && !kl;
      @(posedge clk_i);
      if (kl) begin
         model_q.delete();
      end else begin
         if (pop) void'(model_q.pop_front());
         if (push) model_q.push_back(b);
      end
   endtask

   initial begin
      bundle_t idle, b;
      slot_t [DW-1:0] sl;
      idle = '0;
      reset_i = 1'b1; kill_i = 1'b0; if_valid_i = 1'b0; dp_ready_i = 1'b0;
      if_inst_i = '0; if_mask_i = '0; if_pc_i = '0;

      // reset state
      #12;
      chk("rst_if_ready", 64'(if_ready_o), 64'd0);
      chk("rst_dp_valid", 64'(dp_valid_o), 64'd0);
      chk("rst_dp_count", 64'(dp_count_o), 64'd0);
      chk("rst_dp_mask", 64'(dp_mask_o), 64'd0);
      chk("rst_dp_pc", 64'(dp_pc_o), 64'd0);
      chk("rst_dp_uop", 64'(dp_uop_o == '0), 64'd1);
      @(negedge clk_i); reset_i = 1'b0; #1;
      chk("post_rst_if_ready", 64'(if_ready_o), 64'd1);

      // single push: addi x1,x0,5 ; add x3,x1,x2
      sl[0] = mk_slot(K_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
      sl[1] = mk_slot(K_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
      step(1'b1, mk_bundle(sl, 2'b11, 32'h8000_0000), 1'b0, 1'b0);
      step(1'b0, idle, 1'b1, 1'b0);
      step(1'b0, idle, 1'b0, 1'b0);

      // fill with backpressure, one refused push, then drain in order
      for (int i = 0; i < DEPTH; i++) step(1'b1, rand_bundle(1'b1), 1'b0, 1'b0);
      step(1'b1, rand_bundle(1'b1), 1'b0, 1'b0);
      step(1'b0, idle, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, idle, 1'b1, 1'b0);
      step(1'b0, idle, 1'b0, 1'b0);

      // illegal slot 0 truncates slot 1
      sl[0] = mk_slot(K_BAD, 5'd0, 5'd0, 5'd0, 32'd0);
      sl[1] = mk_slot(K_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
      step(1'b1, mk_bundle(sl, 2'b11, 32'h8000_0010), 1'b0, 1'b0);
      step(1'b0, idle, 1'b1, 1'b0);

      // kill with three queued and an incoming bundle
      for (int i = 0; i < 3; i++) step(1'b1, rand_bundle(1'b1), 1'b0, 1'b0);
      step(1'b1, rand_bundle(1'b1), 1'b1, 1'b1);
      step(1'b0, idle, 1'b0, 1'b0);

      // async reset between edges with two queued
      step(1'b1, rand_bundle(1'b1), 1'b0, 1'b0);
      step(1'b1, rand_bundle(1'b1), 1'b0, 1'b0);
      @(negedge clk_i);
      if_valid_i = 1'b0; dp_ready_i = 1'b0; kill_i = 1'b0;
      #2;
      chk("pre_arst_count", 64'(dp_count_o), 64'(model_q.size()));
      reset_i = 1'b1;
      #1;
      chk("arst_dp_valid", 64'(dp_valid_o), 64'd0);
      chk("arst_dp_count", 64'(dp_count_o), 64'd0);
      chk("arst_dp_mask", 64'(dp_mask_o), 64'd0);
      chk("arst_if_ready", 64'(if_ready_o), 64'd0);
      model_q.delete();
      @(negedge clk_i); reset_i = 1'b0;

      // push into an empty queue with dispatch ready
      step(1'b1, rand_bundle(1'b1), 1'b1, 1'b0);
      step(1'b0, idle, 1'b1, 1'b0);
      step(1'b0, idle, 1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         b = rand_bundle(1'b0);
         step(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
      end
      step(1'b0, idle, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
